// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

    localparam int SUB_W = 8;

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// One-bit full adder; the subtractor feeds it the inverted subtrahend bit.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-adder cell, W cycles per operation.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         overflow,
    output sub_state_t   state_dbg
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    sub_state_t    state, state_n;
    logic [W-1:0]  a_sh, b_sh;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          fa_s, fa_c;

    fa_cell u_fa (
        .x    (a_sh[0]),
        .y    (~b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)       state_n = SHIFT;
            SHIFT:   if (cnt == LAST)    state_n = DONE;
            DONE:    if (out_ready)      state_n = IDLE;
            default:                     state_n = IDLE;
        endcase
    end

    // Handshake flags come straight from the state register, no input paths.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            diff     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        diff  <= '0;
                    end
                end
                SHIFT: begin
                    diff  <= {fa_s, diff[W-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    // carry still holds the carry into the MSB on the last step
                    if (cnt == LAST) begin
                        borrow   <= ~fa_c;
                        overflow <= carry ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at W=8.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    sub_state_t   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [W+1:0] exp_q[$];

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {overflow, borrow, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, sx, sy, sd;
        logic [W-1:0] d;
        logic bo, ov;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        sd = sx - sy;
        d  = W'((ux - uy + 256) % 256);
        bo = (ux < uy);
        ov = (sd < -128) || (sd > 127);
        return {ov, bo, d};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, diff, borrow, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b diff=%h borrow=%b ovf=%b, want 1 0 00 0 0",
                     in_ready, out_valid, diff, borrow, overflow);
        end
    endtask

    // One operation: accept, measure latency, optional stall in DONE, then consume.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int stall, input bit pulse);
        logic [W+1:0] exp_v, held;
        int lat, n;
        exp_q.push_back(model(ta, tb_v));
        a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
            in_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < W + 4) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat !== W) begin
            n_bad++;
            $display("FAIL latency a=%h b=%h: got %0d cycles, want %0d", ta, tb_v, lat, W);
        end
        exp_v = exp_q.pop_front();
        if (!out_valid) return;
        n_cmp++;
        if ({overflow, borrow, diff} !== exp_v) begin
            n_bad++;
            $display("FAIL result a=%h b=%h: got ovf=%b borrow=%b diff=%h, want ovf=%b borrow=%b diff=%h",
                     ta, tb_v, overflow, borrow, diff, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
        end
        held = {overflow, borrow, diff};
        for (int s = 0; s < stall; s++) begin
            if (pulse) in_valid = (s % 2 == 0);
            @(negedge clk);
            n_cmp++;
            if ({overflow, borrow, diff} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall a=%h b=%h cycle %0d: got out=%h in_ready=%b out_valid=%b, want out=%h 0 1",
                         ta, tb_v, s, {overflow, borrow, diff}, in_ready, out_valid, held);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_dbg !== IDLE) begin
            n_bad++;
            $display("FAIL release a=%h b=%h: got in_ready=%b out_valid=%b state=%0d, want 1 0 IDLE",
                     ta, tb_v, in_ready, out_valid, state_dbg);
        end
    endtask

    task automatic test_directed();
        run_op(8'h2D, 8'h0F, 0, 1'b0);
        run_op(8'h03, 8'h05, 0, 1'b0);
        run_op(8'h80, 8'h01, 0, 1'b0);
        run_op(8'h7F, 8'hFF, 0, 1'b0);
        run_op(8'h00, 8'h00, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h00, 8'hFF, 0, 1'b0);
        run_op(8'hFF, 8'h00, 0, 1'b0);
        run_op(8'h80, 8'h7F, 0, 1'b0);
        run_op(8'h7F, 8'h80, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(8'h5A, 8'hC3, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int got;
        logic [W+1:0] exp_v;
        got = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom);
        for (int t = 0; t < 200 && got < 6; t++) begin
            if (out_valid) begin
                exp_v = exp_q.pop_front();
                got++;
                n_cmp++;
                if ({overflow, borrow, diff} !== exp_v) begin
                    n_bad++;
                    $display("FAIL b2b_result %0d: got %h, want %h", got, {overflow, borrow, diff}, exp_v);
                end
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(model(a, b));
                acc.push_back(cyc);
            end else if (!in_ready) begin
                a = W'($urandom); b = W'($urandom);
                if (acc.size() >= 6) in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (got !== 6) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results, want 6", got);
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] !== W + 2) begin
                n_bad++;
                $display("FAIL b2b_interval %0d: got %0d cycles, want %0d", i, acc[i] - acc[i-1], W + 2);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        a = 8'hAA; b = 8'h55; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h00) begin
                n_bad++;
                $display("FAIL midreset cycle %0d: got out_valid=%b in_ready=%b diff=%h, want 0 1 00",
                         i, out_valid, in_ready, diff);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        run_op(8'h00, 8'h00, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++)
            run_op(W'($urandom), W'($urandom), $urandom_range(0, 3), 1'(i % 2));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d pending results, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
